// File: rtl/vx_exec_dispatch_mux_pkg.sv
// Shared types for the execute-stage dispatch mux.
// Tag-width helper, tagged FIFO entry, wis position.
package VX_gpu_pkg;

   // Tag width for a batch of issue/blocks slots.
   function automatic int EXEC_TAG_W(int issue, int blocks);
      int b;
      b = issue / blocks;
      return (b > 1) ? $clog2(b) : 1;
   endfunction

   localparam int WIS_LSB = 0;

   localparam int EXEC_DATAW = 64;
   localparam int EXEC_TAGW  = EXEC_TAG_W(4, 2);

   typedef struct packed {
      logic [EXEC_DATAW-1:0] data;
      logic [EXEC_TAGW-1:0]  tag;
   } exec_tagged_t;

endpackage

// File: rtl/vx_exec_dispatch_mux_if.sv
// Dispatch bus: issue slots in, block outputs out.
// master = issue/exec side, slave = dispatch mux.
interface vx_exec_dispatch_if #(
   parameter int ISSUE_WIDTH = 4,
   parameter int NUM_BLOCKS  = 2,
   parameter int DATAW       = 64,
   parameter int TAG_W       = 1
);
   logic [ISSUE_WIDTH-1:0]            in_valid;
   logic [ISSUE_WIDTH-1:0]            in_ready;
   logic [ISSUE_WIDTH-1:0][DATAW-1:0] in_data;
   logic [ISSUE_WIDTH-1:0]            in_halt;
   logic [NUM_BLOCKS-1:0]             out_valid;
   logic [NUM_BLOCKS-1:0]             out_ready;
   logic [NUM_BLOCKS-1:0][DATAW-1:0]  out_data;
   logic [NUM_BLOCKS-1:0][TAG_W-1:0]  out_tag;

   modport master (
      output in_valid, in_data, in_halt, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );

   modport slave (
      input  in_valid, in_data, in_halt, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );
endinterface

// File: rtl/vx_exec_dispatch_mux_fifo.sv
// Registered per-block FIFO, async active-low reset.
// push/wdata in, pop in, rdata/count/full/empty out.
module vx_exec_lane_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   // Empty output reads as zero so stale entries never leak.
   assign rdata = empty ? '0 : mem[rptr];
endmodule

// File: rtl/vx_exec_dispatch_mux.sv
// Issue-to-block dispatch mux: RR arbiter + FIFO per block.
// Ports: clk, reset_n, bus (slave), perf_ops, sim_ebreak.
module vx_exec_dispatch_mux
   import VX_gpu_pkg::*;
#(
   parameter int ISSUE_WIDTH = 4,
   parameter int NUM_BLOCKS  = 2,
   parameter int DATAW       = 64,
   parameter int WIS_W       = 2,
   parameter int FIFO_DEPTH  = 2,
   parameter int PERF_W      = 32,
   parameter int TAG_W       = EXEC_TAG_W(ISSUE_WIDTH, NUM_BLOCKS)
) (
   input  logic                              clk,
   input  logic                              reset_n,
   vx_exec_dispatch_if.slave                 bus,
   output logic [NUM_BLOCKS-1:0][PERF_W-1:0] perf_ops,
   output logic                              sim_ebreak
);
   localparam int BATCH = ISSUE_WIDTH / NUM_BLOCKS;
   localparam int FW    = DATAW + TAG_W;
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [DATAW-1:0] data;
      logic [TAG_W-1:0] tag;
   } tagged_t;

   logic [NUM_BLOCKS-1:0][BATCH-1:0] blk_rdy;
   logic [NUM_BLOCKS-1:0]            halt_hit;
   logic [ISSUE_WIDTH-1:0]           rdy;

   for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_blk
      logic [BATCH-1:0]            v;
      logic [BATCH-1:0]            hv;
      logic [BATCH-1:0]            gnt;
      logic [BATCH-1:0][DATAW-1:0] d;
      logic [DATAW-1:0]            wsel;
      logic [TAG_W-1:0]            gidx;
      logic                        found;
      logic                        full;
      logic                        empty;
      logic                        accept;
      logic                        pop;
      logic [CW-1:0]               count;
      tagged_t                     wdata;
      tagged_t                     rdata;
      logic [PERF_W-1:0]           ops;

      for (genvar k = 0; k < BATCH; k++) begin : g_slot
         localparam int S = k * NUM_BLOCKS + b;
         assign v[k]  = bus.in_valid[S];
         assign d[k]  = bus.in_data[S];
         assign hv[k] = bus.in_halt[S] &&
            (bus.in_data[S][WIS_LSB +: WIS_W] == '0);
      end

      if (BATCH > 1) begin : g_rr
         logic [TAG_W-1:0] rr_ptr;

         // First valid slot at or after rr_ptr, wrapping.
         always_comb begin
            gnt   = '0;
            gidx  = '0;
            found = 1'b0;
            for (int j = 0; j < BATCH; j++) begin
               int idx;
               idx = (int'(rr_ptr) + j) % BATCH;
               if (!found && v[idx]) begin
                  found    = 1'b1;
                  gnt[idx] = 1'b1;
                  gidx     = TAG_W'(idx);
               end
            end
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               rr_ptr <= '0;
            end else if (accept) begin
               rr_ptr <= (int'(gidx) == BATCH - 1) ?
                  '0 : gidx + 1'b1;
            end
         end
      end else begin : g_single
         assign gnt   = v;
         assign gidx  = '0;
         assign found = v[0];
      end

      always_comb begin
         wsel = '0;
         for (int k = 0; k < BATCH; k++) begin
            if (gnt[k]) wsel = d[k];
         end
      end

      // Gated by reset_n so nothing is accepted while held.
      assign accept      = found && !full && reset_n;
      assign blk_rdy[b]  = gnt & {BATCH{accept}};
      assign halt_hit[b] = accept && |(gnt & hv);
      assign wdata.data  = wsel;
      assign wdata.tag   = gidx;
      assign pop         = !empty && bus.out_ready[b];

      vx_exec_lane_fifo #(
         .WIDTH (FW),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .reset_n (reset_n),
         .push    (accept),
         .wdata   (wdata),
         .pop     (pop),
         .rdata   (rdata),
         .count   (count),
         .full    (full),
         .empty   (empty)
      );

      assign bus.out_valid[b] = (count != '0);
      assign bus.out_data[b]  = rdata.data;
      assign bus.out_tag[b]   = rdata.tag;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            ops <= '0;
         end else if (accept) begin
            ops <= ops + 1'b1;
         end
      end

      assign perf_ops[b] = ops;
   end

   always_comb begin
      rdy = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         rdy[i] = blk_rdy[i % NUM_BLOCKS][i / NUM_BLOCKS];
      end
   end

   assign bus.in_ready = rdy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sim_ebreak <= 1'b0;
      end else if (|halt_hit) begin
         sim_ebreak <= 1'b1;
      end
   end
endmodule

// File: tb/tb_vx_exec_dispatch_mux.sv
// Scoreboard bench for vx_exec_dispatch_mux.
// Model predicts grants, FIFO contents, counters, halt.
module tb_vx_exec_dispatch_mux;
   import VX_gpu_pkg::*;

   localparam int IW    = 4;
   localparam int NB    = 2;
   localparam int DW    = 64;
   localparam int DEPTH = 2;
   localparam int PW    = 4;
   localparam int BATCH = IW / NB;
   localparam int TW    = EXEC_TAG_W(IW, NB);

   logic clk;
   logic reset_n;
   logic [NB-1:0][PW-1:0] perf_ops;
   logic sim_ebreak;

   vx_exec_dispatch_if #(
      .ISSUE_WIDTH (IW),
      .NUM_BLOCKS  (NB),
      .DATAW       (DW),
      .TAG_W       (TW)
   ) bus ();

   vx_exec_dispatch_mux #(
      .ISSUE_WIDTH (IW),
      .NUM_BLOCKS  (NB),
      .DATAW       (DW),
      .WIS_W       (2),
      .FIFO_DEPTH  (DEPTH),
      .PERF_W      (PW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .perf_ops   (perf_ops),
      .sim_ebreak (sim_ebreak)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   exec_tagged_t mq [NB][$];
   int           rr [NB];
   logic [PW-1:0] mperf [NB];
   logic          meb;
   logic [31:0]   seq = 0;

   task automatic check(string tag, logic [63:0] got,
                        logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int b = 0; b < NB; b++) begin
         mq[b].delete();
         rr[b] = 0;
         mperf[b] = '0;
      end
      meb = 1'b0;
   endtask

   task automatic drive(logic [IW-1:0] v, logic [NB-1:0] r,
                        logic [IW-1:0] h);
      bus.in_valid  = v;
      bus.out_ready = r;
      bus.in_halt   = h;
      for (int i = 0; i < IW; i++) begin
         bus.in_data[i] = {seq, 24'h0, 6'(i), 2'b01};
      end
      seq++;
   endtask

   // Compare everything against the model, then advance it.
   task automatic step();
      logic [IW-1:0] er;
      logic [NB-1:0] acc;
      int ak [NB];
      exec_tagged_t e;
      #1;
      er  = '0;
      acc = '0;
      for (int b = 0; b < NB; b++) begin
         ak[b] = 0;
         for (int j = 0; j < BATCH; j++) begin
            int k;
            k = (rr[b] + j) % BATCH;
            if (!acc[b] && bus.in_valid[k*NB+b]) begin
               acc[b] = 1'b1;
               ak[b]  = k;
            end
         end
         if (acc[b] && mq[b].size() < DEPTH && reset_n)
            er[ak[b]*NB+b] = 1'b1;
         else
            acc[b] = 1'b0;
      end
      check("in_ready", 64'(bus.in_ready), 64'(er));
      for (int b = 0; b < NB; b++) begin
         check("out_valid", 64'(bus.out_valid[b]),
               64'(mq[b].size() != 0));
         if (mq[b].size() != 0) begin
            check("out_data", bus.out_data[b], mq[b][0].data);
            check("out_tag", 64'(bus.out_tag[b]),
                  64'(mq[b][0].tag));
         end else begin
            check("idle_data", bus.out_data[b], 64'h0);
         end
         check("perf_ops", 64'(perf_ops[b]), 64'(mperf[b]));
      end
      check("sim_ebreak", 64'(sim_ebreak), 64'(meb));
      for (int b = 0; b < NB; b++) begin
         if (mq[b].size() != 0 && bus.out_ready[b])
            void'(mq[b].pop_front());
         if (acc[b]) begin
            int i;
            i = ak[b] * NB + b;
            e.data = bus.in_data[i];
            e.tag  = TW'(ak[b]);
            mq[b].push_back(e);
            mperf[b] = mperf[b] + 1'b1;
            rr[b] = (ak[b] + 1) % BATCH;
            if (bus.in_halt[i] && bus.in_data[i][1:0] == 2'b00)
               meb = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      model_clear();
      check("rst_in_ready", 64'(bus.in_ready), 64'h0);
      check("rst_out_valid", 64'(bus.out_valid), 64'h0);
      check("rst_out_data0", bus.out_data[0], 64'h0);
      check("rst_out_tag", 64'(bus.out_tag), 64'h0);
      check("rst_perf", 64'(perf_ops), 64'h0);
      check("rst_ebreak", 64'(sim_ebreak), 64'h0);
      @(posedge clk);
      #1;
      check("rst_hold_valid", 64'(bus.out_valid), 64'h0);
      check("rst_hold_ready", 64'(bus.in_ready), 64'h0);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      model_clear();
      drive(4'b1111, 2'b11, 4'b0000);
      @(negedge clk);
      do_reset();

      // First accept after release: slot 0, tag 0.
      for (int c = 0; c < 4; c++) begin
         drive(4'b1111, 2'b11, 4'b0000);
         step();
      end

      // Round-robin on block 0 with slots 0 and 2.
      for (int c = 0; c < 10; c++) begin
         drive(4'b0101, 2'b11, 4'b0000);
         step();
      end

      // Backpressure on block 1, then release.
      for (int c = 0; c < 5; c++) begin
         drive(4'b0010, 2'b01, 4'b0000);
         step();
      end
      check("bp_blocked", 64'(bus.in_ready[1]), 64'h0);
      for (int c = 0; c < 5; c++) begin
         drive(4'b0010, 2'b11, 4'b0000);
         step();
      end

      // Full FIFO, then continuous push/pop.
      for (int c = 0; c < 3; c++) begin
         drive(4'b1010, 2'b01, 4'b0000);
         step();
      end
      for (int c = 0; c < 6; c++) begin
         drive(4'b1010, 2'b11, 4'b0000);
         step();
      end

      // Halt with wis=1 must not set the flag.
      drive(4'b1000, 2'b11, 4'b1000);
      step();
      drive(4'b0000, 2'b11, 4'b0000);
      step();
      check("halt_wis1", 64'(sim_ebreak), 64'h0);
      drive(4'b1000, 2'b11, 4'b1000);
      bus.in_data[3][1:0] = 2'b00;
      step();
      check("halt_set", 64'(sim_ebreak), 64'h1);
      for (int c = 0; c < 3; c++) begin
         drive(4'b0000, 2'b11, 4'b0000);
         step();
      end
      check("halt_sticky", 64'(sim_ebreak), 64'h1);

      // Counter wrap: 17 accepts into block 0.
      do_reset();
      for (int c = 0; c < 17; c++) begin
         drive(4'b0001, 2'b11, 4'b0000);
         step();
      end
      #1;
      check("perf_wrap", 64'(perf_ops[0]), 64'h1);
      drive(4'b0000, 2'b11, 4'b0000);
      step();

      // Random traffic.
      for (int c = 0; c < 300; c++) begin
         drive(4'($urandom), 2'($urandom),
               ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0);
         for (int i = 0; i < IW; i++)
            bus.in_data[i][1:0] = 2'($urandom);
         step();
      end

      // Mid-operation reset discards FIFO contents.
      drive(4'b1111, 2'b00, 4'b0000);
      step();
      #2;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         drive(4'($urandom), 2'($urandom), 4'h0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
